// File: rtl/addsub_pkg.sv
// -----------------------------------------------------------------------------
// addsub_pkg
// Shared definitions for the nibble-serial add/subtract controller.
//   NIBBLE_W : width of the shared arithmetic slice (4 bits)
//   state_t  : controller FSM states (IDLE, RUN, DONE)
// -----------------------------------------------------------------------------
package addsub_pkg;

   localparam int NIBBLE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage : addsub_pkg

// File: rtl/nibble_addsub.sv
// -----------------------------------------------------------------------------
// nibble_addsub
// Purely combinational 4-bit add/subtract slice.
//   i_a, i_b : operand nibbles
//   i_cin    : carry into bit 0
//   i_sub    : 1 = use inverted B (caller supplies cin=1 for true subtract)
//   o_s      : 4-bit result, modulo 16
//   o_cout   : carry out of bit 3
//   o_c3     : carry into bit 3 (used by the caller for signed overflow)
// -----------------------------------------------------------------------------
module nibble_addsub
   import addsub_pkg::*;
(
   input  logic [NIBBLE_W-1:0] i_a,
   input  logic [NIBBLE_W-1:0] i_b,
   input  logic                i_cin,
   input  logic                i_sub,
   output logic [NIBBLE_W-1:0] o_s,
   output logic                o_cout,
   output logic                o_c3
);

   logic [NIBBLE_W-1:0] w_b_eff;
   logic [NIBBLE_W-1:0] w_low;   // bits 2:0 plus their carry into bit 3
   logic [1:0]          w_top;   // bit 3 plus carry out

   assign w_b_eff = i_sub ? ~i_b : i_b;

   // Split at bit 3 so the carry into the MSB is visible for overflow.
   assign w_low = {1'b0, i_a[2:0]} + {1'b0, w_b_eff[2:0]} + {3'b000, i_cin};
   assign w_top = {1'b0, i_a[3]} + {1'b0, w_b_eff[3]} + {1'b0, w_low[3]};

   assign o_s    = {w_top[0], w_low[2:0]};
   assign o_cout = w_top[1];
   assign o_c3   = w_low[3];

endmodule : nibble_addsub

// File: rtl/serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// serial_addsub_ctrl
// Computes A+B+cin or A-B over N_NIBBLES clock cycles using one shared 4-bit
// slice, least-significant nibble first.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in IDLE (and 0 while reset is held and on the
// first cycle out of reset); out_valid is 1 only in DONE and the result is
// held stable until out_ready is seen.
//
// Ports
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid / in_ready  : request handshake
//   in_a, in_b           : W-bit operands (W = 4*N_NIBBLES)
//   in_sub               : 1 = A-B, 0 = A+B
//   in_cin               : carry-in, add only (subtract always injects 1)
//   out_valid / out_ready: result handshake
//   out_sum              : W-bit result, held in IDLE until overwritten
//   out_cout             : carry out of MSB (subtract: 1 = no borrow)
//   out_ovf              : two's-complement signed overflow
//   o_dbg_state          : current FSM state, for observation only
// -----------------------------------------------------------------------------
module serial_addsub_ctrl
   import addsub_pkg::*;
#(
   parameter int N_NIBBLES = 4
)(
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [NIBBLE_W*N_NIBBLES-1:0]   in_a,
   input  logic [NIBBLE_W*N_NIBBLES-1:0]   in_b,
   input  logic                            in_sub,
   input  logic                            in_cin,
   output logic                            out_valid,
   input  logic                            out_ready,
   output logic [NIBBLE_W*N_NIBBLES-1:0]   out_sum,
   output logic                            out_cout,
   output logic                            out_ovf,
   output logic [1:0]                      o_dbg_state
);

   localparam int W     = NIBBLE_W * N_NIBBLES;
   localparam int IDX_W = (N_NIBBLES > 1) ? $clog2(N_NIBBLES) : 1;

   state_t              r_state;
   logic                r_in_ready;
   logic                r_out_valid;
   logic [W-1:0]        r_sum;
   logic                r_cout;
   logic                r_ovf;
   logic [IDX_W-1:0]    r_idx;
   logic                r_carry;
   logic [W-1:0]        r_a;      // shifted right one nibble per RUN cycle
   logic [W-1:0]        r_b;
   logic                r_sub;

   logic [NIBBLE_W-1:0] w_s;
   logic                w_cout;
   logic                w_c3;
   logic                w_last;

   // The operand registers shift, so the slice always sees the low nibble.
   nibble_addsub u_slice (
      .i_a    (r_a[NIBBLE_W-1:0]),
      .i_b    (r_b[NIBBLE_W-1:0]),
      .i_cin  (r_carry),
      .i_sub  (r_sub),
      .o_s    (w_s),
      .o_cout (w_cout),
      .o_c3   (w_c3)
   );

   assign w_last = (r_idx == IDX_W'(N_NIBBLES - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_in_ready  <= 1'b0;
         r_out_valid <= 1'b0;
         r_sum       <= '0;
         r_cout      <= 1'b0;
         r_ovf       <= 1'b0;
         r_idx       <= '0;
         r_carry     <= 1'b0;
         r_a         <= '0;
         r_b         <= '0;
         r_sub       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (r_in_ready && in_valid) begin
                  r_a        <= in_a;
                  r_b        <= in_b;
                  r_sub      <= in_sub;
                  r_idx      <= '0;
                  // Subtract is A + ~B + 1, so cin is ignored there.
                  r_carry    <= in_sub ? 1'b1 : in_cin;
                  r_in_ready <= 1'b0;
                  r_state    <= RUN;
               end else begin
                  // Also raises in_ready on the first edge after reset.
                  r_in_ready <= 1'b1;
               end
            end

            RUN: begin
               // Only the addressed nibble changes; the rest keep the old result.
               for (int k = 0; k < N_NIBBLES; k++) begin
                  if (r_idx == IDX_W'(k)) begin
                     r_sum[k*NIBBLE_W +: NIBBLE_W] <= w_s;
                  end
               end
               r_carry <= w_cout;
               r_a     <= r_a >> NIBBLE_W;
               r_b     <= r_b >> NIBBLE_W;
               if (w_last) begin
                  r_idx       <= '0;
                  r_cout      <= w_cout;
                  // Overflow = carry into MSB xor carry out of MSB.
                  r_ovf       <= w_c3 ^ w_cout;
                  r_out_valid <= 1'b1;
                  r_state     <= DONE;
               end else begin
                  r_idx <= r_idx + 1'b1;
               end
            end

            DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= IDLE;
               end
            end

            default: begin
               r_out_valid <= 1'b0;
               r_in_ready  <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign in_ready    = r_in_ready;
   assign out_valid   = r_out_valid;
   assign out_sum     = r_sum;
   assign out_cout    = r_cout;
   assign out_ovf     = r_ovf;
   assign o_dbg_state = r_state;

endmodule : serial_addsub_ctrl

// File: tb/tb_serial_addsub_ctrl.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub_ctrl
// Directed table of operations with hand-computed results, plus sequences for
// backpressure and reset in the middle of an operation.
// -----------------------------------------------------------------------------
module tb_serial_addsub_ctrl;

   localparam int W = 16;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_sub;
   logic          in_cin;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_cout;
   logic          out_ovf;
   logic [1:0]    dbg_state;

   int n_checks = 0;
   int n_errors = 0;

   // Expected results: {cout, ovf, sum}
   logic [W+1:0] exp_q[$];

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         sub;
      logic         cin;
      logic [W-1:0] exp_sum;
      logic         exp_cout;
      logic         exp_ovf;
   } vec_t;

   vec_t vecs[12];

   serial_addsub_ctrl #(.N_NIBBLES(4)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_a        (in_a),
      .in_b        (in_b),
      .in_sub      (in_sub),
      .in_cin      (in_cin),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_sum     (out_sum),
      .out_cout    (out_cout),
      .out_ovf     (out_ovf),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // ---------------- driver ----------------
   // Issues one request, checks latency and result, then consumes the result.
   task automatic run_op(input vec_t v, input string name);
      int           waited;
      int           lat;
      logic [W+1:0] e;
      waited = 0;
      @(negedge clk);
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) begin
         chk({name, " in_ready timeout"}, 32'(in_ready), 32'd1);
         return;
      end
      in_valid = 1'b1;
      in_a     = v.a;
      in_b     = v.b;
      in_sub   = v.sub;
      in_cin   = v.cin;
      exp_q.push_back({v.exp_cout, v.exp_ovf, v.exp_sum});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      chk({name, " in_ready after accept"}, 32'(in_ready), 32'd0);
      lat = 0;
      while (!out_valid && lat < 20) begin
         // Garbage on the inputs while busy must not disturb the operation.
         in_a   = W'($urandom);
         in_b   = W'($urandom);
         in_sub = 1'($urandom_range(0, 1));
         in_cin = 1'($urandom_range(0, 1));
         @(posedge clk);
         #1;
         lat++;
      end
      chk({name, " latency"}, 32'(lat), 32'd4);
      if (out_valid && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk({name, " sum"},  32'(out_sum),  32'(e[W-1:0]));
         chk({name, " cout"}, 32'(out_cout), 32'(e[W+1]));
         chk({name, " ovf"},  32'(out_ovf),  32'(e[W]));
      end else begin
         exp_q.delete();
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk({name, " out_valid dropped"}, 32'(out_valid), 32'd0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [W-1:0] held_sum;
      logic         held_cout;
      logic         held_ovf;
      vec_t         bp;

      //          a        b        sub   cin   sum      cout  ovf
      vecs[0]  = '{16'h1234, 16'h0FCD, 1'b0, 1'b0, 16'h2201, 1'b0, 1'b0};
      vecs[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[3]  = '{16'h0000, 16'h0001, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0};
      vecs[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1};
      vecs[5]  = '{16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0};
      vecs[6]  = '{16'h0001, 16'h0002, 1'b0, 1'b1, 16'h0004, 1'b0, 1'b0};
      vecs[7]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
      vecs[8]  = '{16'h1234, 16'h1234, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
      vecs[9]  = '{16'h7FFF, 16'hFFFF, 1'b1, 1'b0, 16'h8000, 1'b0, 1'b1};
      vecs[10] = '{16'hFFFF, 16'hFFFF, 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b0};
      vecs[11] = '{16'hA5A5, 16'h5A5A, 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_sub    = 1'b0;
      in_cin    = 1'b0;
      out_ready = 1'b0;

      // ---- reset state ----
      #1;
      chk("reset in_ready",  32'(in_ready),  32'd0);
      chk("reset out_valid", 32'(out_valid), 32'd0);
      chk("reset out_sum",   32'(out_sum),   32'd0);
      chk("reset cout",      32'(out_cout),  32'd0);
      chk("reset ovf",       32'(out_ovf),   32'd0);
      chk("reset state",     32'(dbg_state), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("in_ready before first edge", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      chk("in_ready first edge", 32'(in_ready), 32'd1);

      // ---- table ----
      for (int i = 0; i < 12; i++) begin
         run_op(vecs[i], $sformatf("vec%0d", i));
      end

      // ---- backpressure: hold result 5 cycles with new requests pulsing ----
      bp = '{16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0};
      @(negedge clk);
      in_valid = 1'b1;
      in_a = bp.a; in_b = bp.b; in_sub = bp.sub; in_cin = bp.cin;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("bp out_valid", 32'(out_valid), 32'd1);
      chk("bp sum",       32'(out_sum),   32'(bp.exp_sum));
      held_sum  = out_sum;
      held_cout = out_cout;
      held_ovf  = out_ovf;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         in_valid = 1'(c % 2 == 0);
         in_a     = 16'hBEEF;
         in_b     = 16'h1111;
         @(posedge clk);
         #1;
         chk($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
         chk($sformatf("bp%0d in_ready", c),  32'(in_ready),  32'd0);
         chk($sformatf("bp%0d sum", c),       32'(out_sum),   32'(held_sum));
         chk($sformatf("bp%0d cout/ovf", c),  32'({out_cout, out_ovf}), 32'({held_cout, held_ovf}));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      chk("bp released out_valid", 32'(out_valid), 32'd0);
      chk("bp released in_ready",  32'(in_ready),  32'd1);
      chk("bp sum held in IDLE",   32'(out_sum),   32'(held_sum));
      repeat (6) @(posedge clk);
      #1;
      chk("bp no stray accept", 32'(out_valid), 32'd0);

      // ---- reset during RUN nibble 2 ----
      @(negedge clk);
      in_valid = 1'b1;
      in_a = 16'h1234; in_b = 16'h4321; in_sub = 1'b0; in_cin = 1'b0;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst in_ready",  32'(in_ready),  32'd0);
      chk("midrst out_valid", 32'(out_valid), 32'd0);
      chk("midrst out_sum",   32'(out_sum),   32'd0);
      chk("midrst cout/ovf",  32'({out_cout, out_ovf}), 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("midrst no result", 32'(out_valid), 32'd0);
      run_op(vecs[0], "after midrst");
      run_op(vecs[4], "after midrst sub");

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   // Hard stop in case the sequence above stalls.
   initial begin
      #200000;
      $display("FAIL global timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule : tb_serial_addsub_ctrl
